// File: rtl/piso_tx_reg_if.sv
// Load handshake and serial output bundle of the PISO transmit register.
// The master side supplies words and the shift enable; the slave side drives the serial bit stream.
interface piso_tx_reg_if #(
    parameter int WIDTH = 4
);
    logic             loadValid;
    logic [WIDTH-1:0] parallelIn;
    logic             loadReady;
    logic             shiftEn;
    logic             serialOut;
    logic             serialValid;
    logic             lastBit;

    modport master (
        output loadValid, parallelIn, shiftEn,
        input  loadReady, serialOut, serialValid, lastBit
    );

    modport slave (
        input  loadValid, parallelIn, shiftEn,
        output loadReady, serialOut, serialValid, lastBit
    );
endinterface

// File: rtl/piso_tx_reg.sv
// Parallel-in serial-out transmitter: first bit appears 1 cycle after load, back-to-back words with no gap.
// Backpressure: shiftEn=0 freezes the current bit; loadReady only opens in IDLE or on an advancing last bit.
module piso_tx_reg #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input logic          clk,
    input logic          rst,
    piso_tx_reg_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic             ser_out, ser_vld, ser_last;
    logic             out_nxt, vld_nxt, last_nxt;
    logic             at_last, load;

    assign at_last       = (state == SHIFT) && (count == LAST);
    assign bus.loadReady = rst && ((state == IDLE) || (at_last && bus.shiftEn));
    assign load          = bus.loadValid && bus.loadReady;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        sreg_nxt  = sreg;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = SHIFT;
                    count_nxt = '0;
                    sreg_nxt  = bus.parallelIn;
                end
            end
            SHIFT: begin
                if (bus.shiftEn) begin
                    if (count == LAST) begin
                        count_nxt = '0;
                        if (load) begin
                            sreg_nxt = bus.parallelIn;
                        end else begin
                            state_nxt = IDLE;
                            sreg_nxt  = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
                        end
                    end else begin
                        count_nxt = count + 1'b1;
                        sreg_nxt  = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Output bits are precomputed from next state so serialOut is a true register.
        vld_nxt  = (state_nxt == SHIFT);
        last_nxt = vld_nxt && (count_nxt == LAST);
        if (vld_nxt) begin
            out_nxt = MSB_FIRST ? sreg_nxt[WIDTH-1] : sreg_nxt[0];
        end else begin
            out_nxt = IDLE_LEVEL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            sreg     <= '0;
            count    <= '0;
            ser_out  <= IDLE_LEVEL;
            ser_vld  <= 1'b0;
            ser_last <= 1'b0;
        end else begin
            state    <= state_nxt;
            sreg     <= sreg_nxt;
            count    <= count_nxt;
            ser_out  <= out_nxt;
            ser_vld  <= vld_nxt;
            ser_last <= last_nxt;
        end
    end

    assign bus.serialOut   = ser_out;
    assign bus.serialValid = ser_vld;
    assign bus.lastBit     = ser_last;
endmodule

// File: tb/tb_piso_tx_reg.sv
// Bench for piso_tx_reg: MSB-first/idle-0 and LSB-first/idle-1 instances against a bit-queue model.
module tb_piso_tx_reg;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    piso_tx_reg_if #(.WIDTH(W)) bus_m ();
    piso_tx_reg_if #(.WIDTH(W)) bus_l ();

    piso_tx_reg #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );
    piso_tx_reg #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Remaining bits of the frame in flight, head is the bit currently on the wire.
    bit qm[$];
    bit ql[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("m_valid", int'(bus_m.serialValid), int'(qm.size() > 0));
        check("m_out",   int'(bus_m.serialOut),   (qm.size() > 0) ? int'(qm[0]) : 0);
        check("m_last",  int'(bus_m.lastBit),     int'(qm.size() == 1));
        check("l_valid", int'(bus_l.serialValid), int'(ql.size() > 0));
        check("l_out",   int'(bus_l.serialOut),   (ql.size() > 0) ? int'(ql[0]) : 1);
        check("l_last",  int'(bus_l.lastBit),     int'(ql.size() == 1));
    endtask

    // One clock: drive inputs, check loadReady, clock, update model, check registered outputs.
    task automatic step(input bit r, input bit lv, input logic [W-1:0] pi, input bit se);
        bit rdy_m, rdy_l;
        rst              = r;
        bus_m.loadValid  = lv;
        bus_m.parallelIn = pi;
        bus_m.shiftEn    = se;
        bus_l.loadValid  = lv;
        bus_l.parallelIn = pi;
        bus_l.shiftEn    = se;
        #1;
        rdy_m = r && ((qm.size() == 0) || (qm.size() == 1 && se));
        rdy_l = r && ((ql.size() == 0) || (ql.size() == 1 && se));
        check("m_ready", int'(bus_m.loadReady), int'(rdy_m));
        check("l_ready", int'(bus_l.loadReady), int'(rdy_l));
        @(posedge clk);
        if (!r) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() > 0 && se) void'(qm.pop_front());
            if (ql.size() > 0 && se) void'(ql.pop_front());
            if (lv && rdy_m) for (int i = W - 1; i >= 0; i--) qm.push_back(pi[i]);
            if (lv && rdy_l) for (int i = 0; i < W; i++) ql.push_back(pi[i]);
        end
        #1;
        check_outputs();
    endtask

    initial begin
        bus_m.loadValid  = 1'b0;
        bus_m.parallelIn = '0;
        bus_m.shiftEn    = 1'b0;
        bus_l.loadValid  = 1'b0;
        bus_l.parallelIn = '0;
        bus_l.shiftEn    = 1'b0;

        // Reset with a load pending, then idle with nothing transmitted.
        step(1'b0, 1'b1, 4'hF, 1'b1);
        step(1'b0, 1'b1, 4'hF, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b1);

        // Single word.
        step(1'b1, 1'b1, 4'b1011, 1'b1);
        repeat (5) step(1'b1, 1'b0, 4'h0, 1'b1);

        // Back-to-back: second word held until accepted on the last bit.
        step(1'b1, 1'b1, 4'b1011, 1'b1);
        repeat (3) step(1'b1, 1'b1, 4'b0110, 1'b1);
        repeat (5) step(1'b1, 1'b0, 4'h0, 1'b1);

        // Stall on bit index 1, then on the last bit with a load waiting.
        step(1'b1, 1'b1, 4'b1011, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        repeat (3) step(1'b1, 1'b1, 4'b0101, 1'b0);
        step(1'b1, 1'b1, 4'b0101, 1'b1);
        repeat (5) step(1'b1, 1'b0, 4'h0, 1'b1);

        // Reset mid-frame, then a fresh word starts from bit index 0.
        step(1'b1, 1'b1, 4'b1011, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        step(1'b0, 1'b1, 4'b1111, 1'b1);
        step(1'b1, 1'b1, 4'b0011, 1'b1);
        repeat (5) step(1'b1, 1'b0, 4'h0, 1'b1);

        // Random traffic with stalls and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 1) == 1),
                 W'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/piso_tx_reg.md
Name: piso_tx_reg

Overview:
Parallel-in serial-out transmit register with a bit counter and FSM. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock, with stall support. It is the transmit end that feeds a serial-in shift register chain. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 4, word length in bits; legal range >= 2.
MSB_FIRST, 1, 1 transmits bit WIDTH-1 first; 0 transmits bit 0 first.
IDLE_LEVEL, 0, value driven on serialOut when no bit is valid.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; one clock; reset is synchronous and active-low.
loadValid  input  1  parallelIn holds a word to transmit.
parallelIn  input  WIDTH  word to transmit; sampled only on an accepted load.
loadReady  output  1  block can accept a word this cycle.
shiftEn  input  1  1 advances the shifter; 0 holds the current bit.
serialOut  output  1  current serial bit, registered.
serialValid  output  1  serialOut carries a frame bit.
lastBit  output  1  serialOut carries the final bit of the current word.

Behaviour:
- Reset: rst=0 sampled at a rising edge forces the following on the next edge:
  - state=IDLE, shift register=0, count=0.
  - serialOut=IDLE_LEVEL, serialValid=0, lastBit=0.
  - Reset has priority over loads and shifts. Any load presented in a reset cycle is discarded.
  - A frame in progress is abandoned immediately and never resumed.
- loadReady is combinational and gated by rst: loadReady = rst & (state==IDLE | (state==SHIFT & count==WIDTH-1 & shiftEn)).
- A load is accepted when loadValid & loadReady at a rising edge.
- States:
  - IDLE:
    - serialValid=0, serialOut=IDLE_LEVEL.
    - An accepted load captures parallelIn and goes to SHIFT, with count=0.
    - First-bit latency is 1 cycle: serialOut shows the first bit in the cycle after acceptance.
    - A load in IDLE is accepted regardless of shiftEn.
  - SHIFT:
    - serialValid=1. serialOut is the bit at index count in transmit order.
    - shiftEn=1 and count<WIDTH-1: count+1, next bit presented.
    - shiftEn=0: count, serialOut and lastBit hold. There is no timeout.
    - count==WIDTH-1 & shiftEn=1 with an accepted load: new word captured, count=0, first bit next cycle. There is no gap cycle.
    - count==WIDTH-1 & shiftEn=1 without a load: go to IDLE.
- Bit order:
  - MSB_FIRST=1 shifts left and takes the MSB.
  - MSB_FIRST=0 shifts right and takes the LSB.
  - Vacated bits fill with 0 (not observable on serialOut).
- lastBit = serialValid & count==WIDTH-1. It stays high through any stall on the last bit.
- Counter width is clog2(WIDTH). The counter never wraps past WIDTH-1.
- A word of WIDTH bits occupies exactly WIDTH cycles when shiftEn stays 1. Each cycle with shiftEn=0 adds one cycle.
- loadValid while loadReady=0 has no effect, and parallelIn is ignored. The source must hold its word.
- Downstream sinks sample serialOut on the falling edge of clk. Each bit is stable for a full cycle, which gives half-cycle margin.

Test Plan (WIDTH=4 unless noted):
1. Reset: hold rst=0 for 2 cycles with loadValid=1, parallelIn=4'hF -> loadReady=0, serialOut=0, serialValid=0 throughout. After rst=1 with loadValid=0 -> loadReady=1 and nothing transmitted.
2. Single word: load 4'b1011 at cycle 0, shiftEn=1 -> serialOut 1,0,1,1 in cycles 1-4 with serialValid=1 and lastBit=1 in cycle 4 only. Cycle 5: serialOut=0, serialValid=0, loadReady=1.
3. Back-to-back: 4'b1011 then 4'b0110, loadValid held -> 8 contiguous valid bits 1,0,1,1,0,1,1,0. lastBit in cycles 4 and 8. Second load accepted in cycle 4.
4. Stall: 4'b1011 with shiftEn=0 for 3 cycles while bit index 1 (value 0) is shown -> serialOut stays 0, serialValid stays 1, loadReady=0. The frame completes in cycle 7. Repeat the stall on the last bit -> lastBit held and loadReady=0 until shiftEn=1.
5. Reset mid-frame: rst=0 one cycle after bit index 1 of 4'b1011 -> idle outputs on the next edge. A subsequent load of 4'b0011 transmits 0,0,1,1 from bit index 0.
6. MSB_FIRST=0, IDLE_LEVEL=1: load 4'b1011 -> serialOut 1,1,0,1, then serialOut=1 with serialValid=0.
